lc_stream_source: RTL
=====================

# lc_stream_source

Stream transmitter that pairs with the team's stream-consuming leetcode solver blocks. A testbench or control path loads an integer array into a local buffer through a simple write port. A `start` pulse then plays the first `len` entries out in index order on a valid/ready stream with back-pressure, ending each frame with `out_tlast` and a `done` pulse. It sits between stimulus/control logic and any solver's `in_*` stream port.

## Interface
- `DATA_SIZE`, 32: width of array elements and stream data.
- `DEPTH`, 128: array capacity in entries. Covers the 100-entry problem limit.
- `ADDR_W`, `$clog2(DEPTH)`: derived index width. Not overridden.
- `clk`  in  1  sole clock; everything is on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  array write strobe.
- `wr_addr`  in  ADDR_W  write index.
- `wr_data`  in  DATA_SIZE  write value.
- `start`  in  1  begin a frame. Single-cycle pulse; the level is sampled.
- `len`  in  ADDR_W+1  number of entries to send. Sampled with `start`.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse when the frame completes.
- `out_tdata`  out  DATA_SIZE  stream data.
- `out_tvalid`  out  1  stream valid.
- `out_tready`  in  1  stream ready from the downstream consumer.
- `out_tlast`  out  1  marks the final beat. Present only with `LC_SRC_TLAST_EN`.

## Operation
- FSM states are IDLE, SEND and DONE.
- **IDLE → SEND:** `start`=1 with `len`≠0. Latch `min(len, DEPTH)` as the beat count and reset the read index to 0.
- **IDLE → DONE:** `start`=1 with `len`=0. No beats are sent.
- **SEND → DONE:** on the handshake of the final beat.
- **DONE → IDLE:** unconditional after one cycle. `done`=1 only while in DONE.
- `busy`=1 exactly while in SEND.
- A beat transfers when `out_tvalid` && `out_tready` on a rising edge.
- Stream rules:
  - `out_tvalid` never depends combinationally on `out_tready`.
  - Once asserted, `out_tvalid`, `out_tdata` and `out_tlast` hold stable until the handshake.
- Beat k carries array[k], for k = 0 … count−1, with no reordering, duplication or loss under any `out_tready` pattern.
- `out_tlast`=1 only on beat count−1.
- Writes are accepted only in IDLE. `wr_en` in SEND or DONE is ignored and the array is unchanged.
- `start` is ignored outside IDLE.
- An out-of-range `wr_addr` (≥ DEPTH) is ignored.
- Reset values: `busy`=0, `done`=0, `out_tvalid`=0, `out_tdata`=0, `out_tlast`=0, FSM in IDLE.
- Array contents are not cleared by reset and are retained across it.
- Reset mid-frame: outputs take their reset values on the next edge and the frame is abandoned. No `done` pulse is issued.

## Timing
- Array reads are synchronous with one cycle of latency.
- A 2-entry output skid buffer sustains 1 beat per cycle while `out_tready`=1.
- `start` sampled at edge T: `busy`=1 from T+1, and first `out_tvalid`=1 at T+2.
- With `out_tready` held at 1, beat k is handshaken at T+2+k.
- With `len`=0, `done`=1 at T+1 and `busy` stays 0.
- `done` is asserted the cycle after the final handshake, at T+2+count with no stalls. `busy` falls in that same cycle.
- A write at edge W is visible to a `start` sampled at W+1 or later.
- After a DONE cycle, a new `start` is accepted in the following IDLE cycle. Minimum start-to-start spacing is count+3 cycles.

## Configuration
- `LC_SRC_TLAST_EN` defined: the `out_tlast` port and its logic exist as specified above.
- Undefined: the `out_tlast` port is omitted. Frame boundaries are signalled only by `done`, and all other behaviour is identical.

## Structure
- Package `lc_pkg` holds:
  - the FSM state enum `lc_src_state_t` (IDLE, SEND, DONE);
  - the default `DATA_SIZE`/`DEPTH` localparams shared with the solver blocks.
- Sub-module `lc_src_ram`: single-write, single-read, synchronous-read register array of `DEPTH`×`DATA_SIZE`.
- The top level holds the FSM, the read/beat counters and the skid buffer.

## Test plan
- **In-order frame:** load [1,2,3,1,1,3], `start` with `len`=6, `out_tready`=1.
  - Expect beats 1,2,3,1,1,3 at T+2…T+7 and `out_tlast` on the 6th beat.
  - Expect `done` at T+8; feed the stream into the good-pairs solver and expect 4 pairs.
- **Back-pressure:** same frame with `out_tready` pattern 1,0,0,1,0,1… (random).
  - Data is held stable on every stall cycle.
  - The identical 6-value sequence is delivered, and `done` comes one cycle after the last handshake.
- **Zero length:** `len`=0 → no `out_tvalid`, `busy` stays 0, `done`=1 at T+1.
- **Length clamp, writes during frame:** `len`=200 with DEPTH=128 → exactly 128 beats.
  - `start` and `wr_en` issued during the frame are ignored.
  - A rerun returns the same data.
- **Reset mid-frame:** `rst_n`=0 after beat 2 → `out_tvalid`=0 and `busy`=0 on the next edge, with no `done`.
  - After reset, a new `start` resends from index 0 with the retained array.
- **Configuration:** build without `LC_SRC_TLAST_EN` → the port is absent and `done` timing is unchanged.

Source files
------------

// File: rtl/lc_pkg.sv
// ============================================================================
// lc_pkg : shared types and default sizes for the lc stream blocks. Rev 1.0
// ============================================================================
`default_nettype none

package lc_pkg;

  localparam int LC_DATA_SIZE = 32;
  localparam int LC_DEPTH     = 128;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } lc_src_state_t;

endpackage

`default_nettype wire

// File: rtl/lc_stream_source_if.sv
// ============================================================================
// lc_stream_source_if : load port, control and output stream of the source.
// Optional out_tlast under LC_SRC_TLAST_EN. Rev 1.0
// ============================================================================
`default_nettype none

interface lc_stream_source_if #(
  parameter int DATA_SIZE = lc_pkg::LC_DATA_SIZE,
  parameter int DEPTH     = lc_pkg::LC_DEPTH
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                 wr_en;
  logic [ADDR_W-1:0]    wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 start;
  logic [ADDR_W:0]      len;
  logic                 busy;
  logic                 done;
  logic [DATA_SIZE-1:0] out_tdata;
  logic                 out_tvalid;
  logic                 out_tready;
`ifdef LC_SRC_TLAST_EN
  logic                 out_tlast;
`endif

  // master: the stream source itself
  modport master (
    input  wr_en, wr_addr, wr_data, start, len, out_tready,
    output busy, done, out_tdata, out_tvalid
`ifdef LC_SRC_TLAST_EN
    , output out_tlast
`endif
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, len, out_tready,
    input  busy, done, out_tdata, out_tvalid
`ifdef LC_SRC_TLAST_EN
    , input out_tlast
`endif
  );

endinterface

`default_nettype wire

// File: rtl/lc_src_ram.sv
// ============================================================================
// lc_src_ram : DEPTH x DATA_SIZE array, one write port, registered read. Rev 1.0
// ============================================================================
`default_nettype none

module lc_src_ram #(
  parameter int DATA_SIZE = 32,
  parameter int DEPTH     = 128,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  wire logic                 clk,
  input  wire logic                 i_we,
  input  wire logic [ADDR_W-1:0]    i_waddr,
  input  wire logic [DATA_SIZE-1:0] i_wdata,
  input  wire logic                 i_re,
  input  wire logic [ADDR_W-1:0]    i_raddr,
  output logic      [DATA_SIZE-1:0] o_rdata
);

  // No reset: contents survive rst_n
  logic [DATA_SIZE-1:0] r_mem [DEPTH];
  logic [DATA_SIZE-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/lc_stream_source.sv
// ============================================================================
// lc_stream_source : plays array[0..len-1] on a valid/ready stream, then done.
// Macro LC_SRC_TLAST_EN adds out_tlast. Rev 1.0
// ============================================================================
`default_nettype none

module lc_stream_source #(
  parameter int DATA_SIZE = lc_pkg::LC_DATA_SIZE,
  parameter int DEPTH     = lc_pkg::LC_DEPTH
) (
  input wire logic            clk,
  input wire logic            rst_n,
  lc_stream_source_if.master  s
);
  import lc_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);

  lc_src_state_t        r_state;
  logic                 r_busy, r_done;
  logic [CNT_W-1:0]     r_count, r_rd_idx;
  logic                 r_rd_vld, r_rd_last;
  logic                 r_head_vld, r_head_last, r_skid_vld, r_skid_last;
  logic [DATA_SIZE-1:0] r_head_data, r_skid_data;

  logic [DATA_SIZE-1:0] w_rdata;
  logic [CNT_W-1:0]     w_len_clamp;
  logic [ADDR_W-1:0]    w_raddr;
  logic [1:0]           w_level;
  logic                 w_pop, w_start_go, w_send_issue, w_re, w_we, w_addr_ok;

  generate
    if (DEPTH == (1 << ADDR_W)) begin : g_addr_full
      assign w_addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign w_addr_ok = ({1'b0, s.wr_addr} < c_DEPTH);
    end
  endgenerate

  // A read is launched only if the 2-entry buffer will still have room when
  // it lands, counting the read already in flight.
  always_comb begin
    w_len_clamp  = (s.len > c_DEPTH) ? c_DEPTH : s.len;
    w_pop        = r_head_vld & s.out_tready;
    w_level      = {1'b0, r_head_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_vld} - {1'b0, w_pop};
    w_start_go   = (r_state == S_IDLE) & s.start & (s.len != '0);
    w_send_issue = (r_state == S_SEND) & (r_rd_idx != r_count) & (w_level <= 2'd1);
    w_re         = w_start_go | w_send_issue;
    w_raddr      = w_start_go ? '0 : r_rd_idx[ADDR_W-1:0];
    w_we         = (r_state == S_IDLE) & s.wr_en & w_addr_ok;
  end

  lc_src_ram #(
    .DATA_SIZE (DATA_SIZE),
    .DEPTH     (DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (s.wr_addr),
    .i_wdata (s.wr_data),
    .i_re    (w_re),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_count     <= '0;
      r_rd_idx    <= '0;
      r_rd_vld    <= 1'b0;
      r_rd_last   <= 1'b0;
      r_head_vld  <= 1'b0;
      r_head_last <= 1'b0;
      r_head_data <= '0;
      r_skid_vld  <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
    end else begin
      r_rd_vld <= w_re;
      if (w_start_go) begin
        r_rd_idx  <= c_ONE;
        r_rd_last <= (w_len_clamp == c_ONE);
      end else if (w_send_issue) begin
        r_rd_idx  <= r_rd_idx + c_ONE;
        r_rd_last <= ((r_rd_idx + c_ONE) == r_count);
      end

      // Head register drives the port; skid catches a read landing during a stall
      if (!r_head_vld || w_pop) begin
        if (r_skid_vld) begin
          r_head_vld  <= 1'b1;
          r_head_data <= r_skid_data;
          r_head_last <= r_skid_last;
          r_skid_vld  <= r_rd_vld;
          if (r_rd_vld) begin
            r_skid_data <= w_rdata;
            r_skid_last <= r_rd_last;
          end
        end else begin
          r_head_vld  <= r_rd_vld;
          r_head_last <= r_rd_vld & r_rd_last;
          if (r_rd_vld) r_head_data <= w_rdata;
        end
      end else if (r_rd_vld) begin
        r_skid_vld  <= 1'b1;
        r_skid_data <= w_rdata;
        r_skid_last <= r_rd_last;
      end

      case (r_state)
        S_IDLE: begin
          if (s.start) begin
            r_count <= w_len_clamp;
            if (s.len != '0) begin
              r_state <= S_SEND;
              r_busy  <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (w_pop && r_head_last) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign s.busy       = r_busy;
  assign s.done       = r_done;
  assign s.out_tdata  = r_head_data;
  assign s.out_tvalid = r_head_vld;
`ifdef LC_SRC_TLAST_EN
  assign s.out_tlast  = r_head_last;
`endif

endmodule

`default_nettype wire
